datapath_regfile: RTL and testbench
===================================

// Module: datapath_regfile
// PURPOSE
//   Register file feeding the datapath logic units (AND/OR/ALU): one write port,
//   two independent read ports with registered outputs. Writer side is the
//   writeback stage; readers are the operand-fetch for A and B. Provides
//   write-to-read bypass so a same-cycle writeback is visible to operand fetch.
// PARAMETERS
//   WIDTH   8  data width of each register, bits
//   DEPTH   8  number of registers (power of two, >= 2)
//   AW      3  address width, must equal log2(DEPTH)
// PORTS
//   clk        in   1      rising-edge clock
//   reset_n    in   1      synchronous reset, active-low
//   wr_en      in   1      write strobe, sampled on rising edge
//   wr_addr    in   AW     write address
//   wr_data    in   WIDTH  write data
//   rd_en_a    in   1      read request, port A
//   rd_addr_a  in   AW     read address, port A
//   rd_data_a  out  WIDTH  registered read data, port A
//   rd_vld_a   out  1      rd_data_a holds the result of the previous cycle's rd_en_a
//   rd_en_b    in   1      read request, port B
//   rd_addr_b  in   AW     read address, port B
//   rd_data_b  out  WIDTH  registered read data, port B
//   rd_vld_b   out  1      as rd_vld_a, port B
// BEHAVIOUR
//   - One clock, synchronous active-low reset: reset_n==0 at a rising edge clears
//     all registers to 0, rd_data_a/b to 0, rd_vld_a/b to 0. Reset wins over any
//     simultaneous write or read in that cycle.
//   - Register 0 is hardwired zero: writes to address 0 are discarded; reads of
//     address 0 return 0 (including via bypass).
//   - Write: wr_en==1 at edge N -> mem[wr_addr] = wr_data after edge N.
//   - Read latency 1: rd_en_x==1 at edge N -> rd_data_x/rd_vld_x=1 valid after edge N.
//     rd_en_x==0 at edge N -> rd_vld_x=0 after edge N; rd_data_x HOLDS its last value.
//   - Bypass: same edge with wr_en==1, rd_en_x==1, rd_addr_x==wr_addr!=0 ->
//     rd_data_x = wr_data (new value), not the old stored value.
//   - Ports A and B are fully independent; same address on both returns identical
//     data; both may bypass in the same cycle.
//   - No back-pressure: every request completes in exactly one cycle; no stall state.
//   - Addresses >= DEPTH cannot occur (AW = log2 DEPTH); no wrap logic needed.
//   - Reset mid-operation: a read issued on the reset edge is dropped (rd_vld=0).
//   - No X propagation: all outputs defined from the first post-reset cycle.
// TESTING
//   1. Reset: hold reset_n=0 2 cycles, read all 8 addrs -> every rd_data=0x00, rd_vld
//      pulses 1 per read, 0 during reset.
//   2. Write 0x5A to addr 3, next cycle rd_en_a addr 3 -> rd_data_a=0x5A, rd_vld_a=1
//      one cycle after request.
//   3. Bypass: mem[5]=0x11, same edge write 0xC3 to addr 5 and rd_en_b addr 5 ->
//      rd_data_b=0xC3.
//   4. Write 0xFF to addr 0, read addr 0 on A and B (also same-cycle bypass case)
//      -> both return 0x00.
//   5. Write 0xA0 addr 2, 0x0F addr 6; read A=2, B=6 same cycle -> 0xA0 / 0x0F;
//      next cycle rd_en=0 -> rd_vld=0, data held at 0xA0 / 0x0F.
//   6. Reset mid-stream: reset_n=0 on an edge with wr_en addr 4=0x77 and rd_en_a addr 4
//      -> rd_vld_a=0, later read addr 4 returns 0x00.

Source files
------------

// File: rtl/datapath_regfile.sv
// Register file for the datapath operand fetch: one write port, two
// independent registered read ports, write-to-read bypass, register 0 is zero.
module datapath_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             rd_vld_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_vld_b
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_a_r;
    logic [WIDTH-1:0] rd_data_b_r;
    logic             rd_vld_a_r;
    logic             rd_vld_b_r;
    logic [WIDTH-1:0] nxt_a_s;
    logic [WIDTH-1:0] nxt_b_s;

    // Port A read data: address 0 forces zero, otherwise a same-edge write wins.
    always_comb begin
        nxt_a_s = {WIDTH{1'b0}};
        if (rd_addr_a == {AW{1'b0}}) begin
            nxt_a_s = {WIDTH{1'b0}};
        end else if (wr_en && (wr_addr == rd_addr_a)) begin
            nxt_a_s = wr_data;
        end else begin
            nxt_a_s = mem_r[rd_addr_a];
        end
    end

    // Port B read data: same selection as port A.
    always_comb begin
        nxt_b_s = {WIDTH{1'b0}};
        if (rd_addr_b == {AW{1'b0}}) begin
            nxt_b_s = {WIDTH{1'b0}};
        end else if (wr_en && (wr_addr == rd_addr_b)) begin
            nxt_b_s = wr_data;
        end else begin
            nxt_b_s = mem_r[rd_addr_b];
        end
    end

    // Storage array; entry 0 is never written so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i[AW-1:0]] <= {WIDTH{1'b0}};
            end
        end else if (wr_en && (wr_addr != {AW{1'b0}})) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read ports; data holds when no request is made.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_a_r <= {WIDTH{1'b0}};
            rd_data_b_r <= {WIDTH{1'b0}};
            rd_vld_a_r  <= 1'b0;
            rd_vld_b_r  <= 1'b0;
        end else begin
            rd_vld_a_r <= rd_en_a;
            rd_vld_b_r <= rd_en_b;
            if (rd_en_a) begin
                rd_data_a_r <= nxt_a_s;
            end
            if (rd_en_b) begin
                rd_data_b_r <= nxt_b_s;
            end
        end
    end

    assign rd_data_a = rd_data_a_r;
    assign rd_data_b = rd_data_b_r;
    assign rd_vld_a  = rd_vld_a_r;
    assign rd_vld_b  = rd_vld_b_r;

endmodule

// File: tb/tb_datapath_regfile.sv
// Scoreboard bench for datapath_regfile: stimulus pushes expected read data,
// a negedge monitor pops and compares whenever a read port reports valid.
module tb_datapath_regfile;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en_a;
    logic [2:0] rd_addr_a;
    logic [7:0] rd_data_a;
    logic       rd_vld_a;
    logic       rd_en_b;
    logic [2:0] rd_addr_b;
    logic [7:0] rd_data_b;
    logic       rd_vld_b;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_a_q [$];
    logic [7:0] exp_b_q [$];

    datapath_regfile #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_vld_a  (rd_vld_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .rd_vld_b  (rd_vld_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // One clock of stimulus; expected read data is queued for the monitor.
    task automatic cyc(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic ea, input logic [2:0] aa, input logic [7:0] xa,
                       input logic eb, input logic [2:0] ab, input logic [7:0] xb);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en_a = ea; rd_addr_a = aa;
        rd_en_b = eb; rd_addr_b = ab;
        if (ea) exp_a_q.push_back(xa);
        if (eb) exp_b_q.push_back(xb);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
    endtask

    // Monitor: pop and compare on every valid read result.
    always @(negedge clk) begin
        if (rd_vld_a === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_vld_a: got data 0x%02h expected no valid", rd_data_a);
            end else begin
                chk("rd_data_a", rd_data_a, exp_a_q.pop_front());
            end
        end
        if (rd_vld_b === 1'b1) begin
            if (exp_b_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_vld_b: got data 0x%02h expected no valid", rd_data_b);
            end else begin
                chk("rd_data_b", rd_data_b, exp_b_q.pop_front());
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
        rd_en_a = 1'b0; rd_addr_a = 3'd0; rd_en_b = 1'b0; rd_addr_b = 3'd0;

        // Reset held two cycles with reads requested: nothing may be valid.
        rd_en_a = 1'b1; rd_en_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_vld_a", {7'd0, rd_vld_a}, 8'h00);
        chk("reset_vld_b", {7'd0, rd_vld_b}, 8'h00);
        chk("reset_data_a", rd_data_a, 8'h00);
        chk("reset_data_b", rd_data_b, 8'h00);
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        reset_n = 1'b1;

        // Every register reads zero after reset.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 8'h00, 1'b1, 3'(7 - i), 8'h00);
        end

        // Write then read one cycle later.
        cyc(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
        chk("vld_a_after_read", {7'd0, rd_vld_a}, 8'h01);

        // Bypass on port B, then the stored value on port A.
        cyc(1'b1, 3'd5, 8'h11, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        cyc(1'b1, 3'd5, 8'hC3, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'hC3);
        cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'hC3, 1'b1, 3'd3, 8'h5A);

        // Register 0 stays zero, including the bypass path.
        cyc(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 8'h00);
        cyc(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 8'h00);

        // Both ports bypass the same write together.
        cyc(1'b1, 3'd7, 8'h3C, 1'b1, 3'd7, 8'h3C, 1'b1, 3'd7, 8'h3C);

        // Independent addresses, then idle: valid drops, data holds.
        cyc(1'b1, 3'd2, 8'hA0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        cyc(1'b1, 3'd6, 8'h0F, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'hA0, 1'b1, 3'd6, 8'h0F);
        cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        chk("idle_vld_a", {7'd0, rd_vld_a}, 8'h00);
        chk("idle_vld_b", {7'd0, rd_vld_b}, 8'h00);
        chk("hold_data_a", rd_data_a, 8'hA0);
        chk("hold_data_b", rd_data_b, 8'h0F);

        // Reset edge with a write and a read in flight: both dropped.
        reset_n = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h77;
        rd_en_a = 1'b1; rd_addr_a = 3'd4;
        @(posedge clk); #1;
        chk("midreset_vld_a", {7'd0, rd_vld_a}, 8'h00);
        chk("midreset_data_a", rd_data_a, 8'h00);
        reset_n = 1'b1; wr_en = 1'b0; rd_en_a = 1'b0;
        cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h00, 1'b1, 3'd3, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        chk("pending_a", 8'(exp_a_q.size()), 8'h00);
        chk("pending_b", 8'(exp_b_q.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
